// File: rtl/cam_capture_if.sv
// cam_capture_if: bundles the camera byte stream (towards the capture stage)
// with the frame-buffer write port and the frame status (away from it).
//   master : camera/frame-buffer side, drives cam_*, observes write port
//   slave  : cam_capture, consumes cam_*, drives wea/addrin/datain/frame_*
interface cam_capture_if #(
    parameter int unsigned c_nb_img_pxls = 13,
    parameter int unsigned c_nb_buf      = 12
);
    logic                     cam_vsync;
    logic                     cam_href;
    logic                     cam_de;
    logic [7:0]               cam_data;
    logic                     wea;
    logic [c_nb_img_pxls-1:0] addrin;
    logic [c_nb_buf-1:0]      datain;
    logic                     frame_done;
    logic                     frame_err;

    modport master (
        output cam_vsync, cam_href, cam_de, cam_data,
        input  wea, addrin, datain, frame_done, frame_err
    );

    modport slave (
        input  cam_vsync, cam_href, cam_de, cam_data,
        output wea, addrin, datain, frame_done, frame_err
    );
endinterface

// File: rtl/cam_capture.sv
// cam_capture: turns an RGB444 camera byte stream (two bytes per pixel) into
// decimated 12-bit pixels, keeping the top-left pixel of each 2^dec x 2^dec
// block, and writes them sequentially into the input frame buffer.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   cam.slave  cam_vsync/cam_href/cam_de/cam_data in (already in clk domain);
//              wea/addrin/datain write port, frame_done pulse, frame_err
//              (sticky until the next frame starts) out
module cam_capture #(
    parameter int unsigned c_nb_img_pxls = 13,
    parameter int unsigned c_nb_buf      = 12,
    parameter int unsigned c_src_cols    = 640,
    parameter int unsigned c_src_rows    = 480,
    parameter int unsigned c_dec_log2    = 3
) (
    input  logic         clk,
    input  logic         rst,
    cam_capture_if.slave cam
);
    localparam int unsigned COL_W   = 10;
    localparam int unsigned ROW_W   = 9;
    localparam int unsigned CNT_W   = c_nb_img_pxls + 1;
    localparam int unsigned NB_KEPT = (c_src_cols >> c_dec_log2) * (c_src_rows >> c_dec_log2);
    localparam logic [COL_W-1:0] COLS      = COL_W'(c_src_cols);
    localparam logic [ROW_W-1:0] ROWS      = ROW_W'(c_src_rows);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(NB_KEPT - 1);

    typedef enum logic [1:0] {S_SYNC, S_VBLANK, S_ACTIVE} state_t;

    state_t                   state_q, state_d;
    logic                     vsync_q, href_q;
    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic                     ph_q, ph_d;
    logic [3:0]               red_q, red_d;
    logic [CNT_W-1:0]         addr_cnt_q, addr_cnt_d;
    logic                     wea_q, wea_d;
    logic [c_nb_img_pxls-1:0] addrin_q, addrin_d;
    logic [c_nb_buf-1:0]      datain_q, datain_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic vs_rise_c, vs_fall_c, href_fall_c, frame_ok_c;

    // Edges compare the live input against its registered previous value.
    assign vs_rise_c   =  cam.cam_vsync & ~vsync_q;
    assign vs_fall_c   = ~cam.cam_vsync &  vsync_q;
    assign href_fall_c = ~cam.cam_href  &  href_q;

    // Next-state, counters and registered outputs.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        ph_d       = ph_q;
        red_d      = red_q;
        addr_cnt_d = addr_cnt_q;
        wea_d      = 1'b0;
        addrin_d   = addrin_q;
        datain_d   = datain_q;
        done_d     = 1'b0;
        err_d      = err_q;
        frame_ok_c = 1'b0;

        case (state_q)
            S_SYNC: begin
                if (cam.cam_vsync) state_d = S_VBLANK;
            end
            S_VBLANK: begin
                col_d      = '0;
                row_d      = '0;
                ph_d       = 1'b0;
                addr_cnt_d = '0;
                if (vs_fall_c) begin
                    state_d = S_ACTIVE;
                    err_d   = 1'b0;
                end
            end
            S_ACTIVE: begin
                if (cam.cam_de && cam.cam_href) begin
                    if (!ph_q) begin
                        red_d = cam.cam_data[3:0];
                        ph_d  = 1'b1;
                    end else begin
                        ph_d = 1'b0;
                        if (col_q != '1) col_d = col_q + COL_W'(1);
                        if (col_q >= COLS || row_q >= ROWS) begin
                            err_d = 1'b1;
                        end else if (col_q[c_dec_log2-1:0] == '0 &&
                                     row_q[c_dec_log2-1:0] == '0) begin
                            if (addr_cnt_q > ADDR_LAST) begin
                                err_d = 1'b1;
                            end else begin
                                wea_d      = 1'b1;
                                addrin_d   = c_nb_img_pxls'(addr_cnt_q);
                                datain_d   = c_nb_buf'({red_q, cam.cam_data});
                                addr_cnt_d = addr_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                // End of line after any byte taken this cycle; a dangling half
                // pixel is simply dropped.
                if (href_fall_c) begin
                    if (ph_q || col_q != COLS || row_q >= ROWS) err_d = 1'b1;
                    if (row_q != '1) row_d = row_q + ROW_W'(1);
                    col_d = '0;
                    ph_d  = 1'b0;
                end
                // Frame is good only if all lines arrived whole and nothing is pending.
                if (vs_rise_c) begin
                    frame_ok_c = !err_d && row_d == ROWS && col_d == '0 && !ph_d;
                    done_d     = frame_ok_c;
                    err_d      = err_d | ~frame_ok_c;
                    state_d    = S_VBLANK;
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_SYNC;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            ph_q       <= 1'b0;
            red_q      <= '0;
            addr_cnt_q <= '0;
            wea_q      <= 1'b0;
            addrin_q   <= '0;
            datain_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            vsync_q    <= cam.cam_vsync;
            href_q     <= cam.cam_href;
            col_q      <= col_d;
            row_q      <= row_d;
            ph_q       <= ph_d;
            red_q      <= red_d;
            addr_cnt_q <= addr_cnt_d;
            wea_q      <= wea_d;
            addrin_q   <= addrin_d;
            datain_q   <= datain_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign cam.wea        = wea_q;
    assign cam.addrin     = addrin_q;
    assign cam.datain     = datain_q;
    assign cam.frame_done = done_q;
    assign cam.frame_err  = err_q;
endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: drives randomized camera frames into a scaled-down
// cam_capture (32x24 source, 4x3 kept pixels) and checks every write and
// every frame status against a model derived from the frame's own content.
module tb_cam_capture;
    localparam int AW   = 13;
    localparam int DW   = 12;
    localparam int COLS = 32;
    localparam int ROWS = 24;
    localparam int DEC  = 3;
    localparam int KEPT = (COLS / 8) * (ROWS / 8);

    logic clk = 1'b0;
    logic rst;
    logic rst_e;
    always #5 clk = ~clk;

    cam_capture_if #(.c_nb_img_pxls(AW), .c_nb_buf(DW)) cam ();

    cam_capture #(
        .c_nb_img_pxls(AW),
        .c_nb_buf     (DW),
        .c_src_cols   (COLS),
        .c_src_rows   (ROWS),
        .c_dec_log2   (DEC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cam(cam)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    wr_t         exp_q[$];
    logic [DW-1:0] fb [0:KEPT-1];
    int          wr_cnt;
    int          cyc;
    int          last_wea_cyc;
    logic [AW-1:0] last_addr;
    logic        done_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle compare: every write must be the next one the model expects.
    initial begin : compare
        wr_t e;
        last_wea_cyc = -100;
        last_addr    = '0;
        done_prev    = 1'b0;
        cyc          = 0;
        wr_cnt       = 0;
        forever begin
            @(posedge clk);
            rst_e = rst;
            #1;
            cyc++;
            if (rst_e) begin
                check("rst_wea",   32'(cam.wea), 0);
                check("rst_addr",  32'(cam.addrin), 0);
                check("rst_data",  32'(cam.datain), 0);
                check("rst_done",  32'(cam.frame_done), 0);
                check("rst_err",   32'(cam.frame_err), 0);
                last_addr = '0;
                done_prev = 1'b0;
            end else begin
                if (cam.wea) begin
                    check("wea_spacing", 32'(cyc - last_wea_cyc >= 2), 1);
                    last_wea_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_wea: got addr 0x%0h data 0x%0h, expected no write",
                                 cam.addrin, cam.datain);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 32'(cam.addrin), 32'(e.addr));
                        check("wr_data", 32'(cam.datain), 32'(e.data));
                    end
                    if (int'(cam.addrin) < KEPT) fb[cam.addrin] = cam.datain;
                    wr_cnt++;
                    last_addr = cam.addrin;
                end else begin
                    check("addr_hold", 32'(cam.addrin), 32'(last_addr));
                end
                if (done_prev && cam.frame_done) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL done_width: got frame_done high 2 cycles, expected 1");
                end
                done_prev = cam.frame_done;
            end
        end
    end

    function automatic logic [7:0] rnd_byte();
        return 8'($urandom);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom);
    endfunction

    // Apply one cycle of camera inputs; returns just after the DUT has registered them.
    task automatic cyc_drive(input logic vs, input logic hr, input logic de, input logic [7:0] d);
        cam.cam_vsync = vs;
        cam.cam_href  = hr;
        cam.cam_de    = de;
        cam.cam_data  = d;
        @(posedge clk);
        #2;
    endtask

    // One frame: optional vblank, nlines lines of ramp pixels, closing vsync rise.
    task automatic send_frame(input int nlines, input int nbytes, input int short_line,
                              input bit cap_in, input bit b2b, input int rst_line,
                              input bit skip_vb);
        bit          cap;
        bit          bad;
        int          maddr;
        int          len;
        int          c;
        logic [11:0] p;
        logic [7:0]  d;
        wr_t         w;
        cap   = cap_in;
        maddr = 0;
        if (!skip_vb) begin
            repeat (6) cyc_drive(1'b1, 1'b0, rnd_bit(), rnd_byte());
            cyc_drive(1'b0, 1'b0, 1'b0, 8'h00);
            if (cap) check("err_cleared", 32'(cam.frame_err), 0);
            repeat (3) cyc_drive(1'b0, 1'b0, rnd_bit(), rnd_byte());
        end
        for (int r = 0; r < nlines; r++) begin
            if (r == rst_line) begin
                rst = 1'b1;
                repeat (2) cyc_drive(1'b0, 1'b0, rnd_bit(), rnd_byte());
                rst = 1'b0;
                cap = 1'b0;
            end
            len = (r == short_line) ? 2 * COLS - 1 : nbytes;
            for (int b = 0; b < len; b++) begin
                c = b / 2;
                p = 12'((r * COLS + c) % 4096);
                if (!b2b) repeat ($urandom_range(0, 2)) cyc_drive(1'b0, 1'b1, 1'b0, rnd_byte());
                d = (b % 2 == 0) ? {4'($urandom), p[11:8]} : p[7:0];
                if (b % 2 == 1 && cap && r < ROWS && c < COLS &&
                    r % 8 == 0 && c % 8 == 0 && maddr < KEPT) begin
                    w.addr = AW'(maddr);
                    w.data = p;
                    exp_q.push_back(w);
                    maddr++;
                end
                cyc_drive(1'b0, 1'b1, 1'b1, d);
            end
            repeat (3) cyc_drive(1'b0, 1'b0, rnd_bit(), rnd_byte());
        end
        bad = (nlines != ROWS) || (nbytes != 2 * COLS) ||
              (short_line >= 0 && short_line < nlines);
        cyc_drive(1'b1, 1'b0, 1'b0, 8'h00);
        check("frame_done", 32'(cam.frame_done), 32'(cap && !bad));
        check("frame_err",  32'(cam.frame_err),  32'(cap && bad));
        check("exp_drained", 32'(exp_q.size()), 0);
        cyc_drive(1'b1, 1'b0, 1'b0, 8'h00);
        check("done_one_cycle", 32'(cam.frame_done), 0);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: got no end of run, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        cam.cam_vsync = 1'b0;
        cam.cam_href  = 1'b0;
        cam.cam_de    = 1'b0;
        cam.cam_data  = 8'h00;
        rst           = 1'b1;

        // Reset with random camera activity, then no writes without a vsync cycle.
        repeat (2) cyc_drive(rnd_bit(), rnd_bit(), rnd_bit(), rnd_byte());
        check("reset_wea",  32'(cam.wea), 0);
        check("reset_addr", 32'(cam.addrin), 0);
        check("reset_data", 32'(cam.datain), 0);
        check("reset_done", 32'(cam.frame_done), 0);
        check("reset_err",  32'(cam.frame_err), 0);
        rst = 1'b0;
        repeat (40) cyc_drive(1'b0, rnd_bit(), rnd_bit(), rnd_byte());

        // Clean ramp frame, with literal pins on the decimated content.
        wr_cnt = 0;
        send_frame(ROWS, 2 * COLS, -1, 1'b1, 1'b0, -1, 1'b0);
        check("ramp_wr_count", 32'(wr_cnt), 12);
        check("ramp_fb0",  32'(fb[0]),  32'h000);
        check("ramp_fb5",  32'(fb[5]),  32'h108);
        check("ramp_fb11", 32'(fb[11]), 32'h218);

        // Reset released mid-line inside an active frame: that frame is skipped.
        rst = 1'b1;
        repeat (2) cyc_drive(1'b0, 1'b1, rnd_bit(), rnd_byte());
        rst = 1'b0;
        for (int b = 0; b < 20; b++) cyc_drive(1'b0, 1'b1, 1'b1, rnd_byte());
        repeat (3) cyc_drive(1'b0, 1'b0, 1'b0, 8'h00);
        wr_cnt = 0;
        send_frame(6, 2 * COLS, -1, 1'b0, 1'b0, -1, 1'b1);
        check("midstart_no_wr", 32'(wr_cnt), 0);
        send_frame(ROWS, 2 * COLS, -1, 1'b1, 1'b0, -1, 1'b0);

        // Short line 8, then a clean frame clears the error.
        send_frame(ROWS, 2 * COLS, 8, 1'b1, 1'b0, -1, 1'b0);
        send_frame(ROWS, 2 * COLS, -1, 1'b1, 1'b0, -1, 1'b0);

        // Oversize frame: extra columns and lines are dropped.
        wr_cnt = 0;
        send_frame(ROWS + 2, 2 * (COLS + 3), -1, 1'b1, 1'b0, -1, 1'b0);
        check("oversize_wr_count", 32'(wr_cnt), 12);
        check("oversize_last_addr", 32'(last_addr), 11);

        // Back-to-back bytes, reset at line 10, then a full back-to-back frame.
        send_frame(ROWS, 2 * COLS, -1, 1'b1, 1'b1, 10, 1'b0);
        wr_cnt = 0;
        send_frame(ROWS, 2 * COLS, -1, 1'b1, 1'b1, -1, 1'b0);
        check("b2b_wr_count", 32'(wr_cnt), 12);
        check("b2b_fb11", 32'(fb[11]), 32'h218);

        repeat (4) cyc_drive(1'b1, 1'b0, 1'b0, 8'h00);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
